// File: rtl/uart_ring_ctrl_if.sv
// Handshake bundle between the ring-buffer controller and its UART/RAM/key neighbours.
// The master side is the environment; the slave side is the controller.
interface uart_ring_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              rx_done;
    logic              tx_done;
    logic              key_flag;
    logic              key_state;
    logic              auto_mode;
    logic [ADDR_W-1:0] wraddress;
    logic              wren;
    logic [ADDR_W-1:0] rdaddress;
    logic              send_en;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;
    logic              busy;

    modport master (
        output rx_done, tx_done, key_flag, key_state, auto_mode,
        input  wraddress, wren, rdaddress, send_en, fill_level, overflow, busy
    );

    modport slave (
        input  rx_done, tx_done, key_flag, key_state, auto_mode,
        output wraddress, wren, rdaddress, send_en, fill_level, overflow, busy
    );
endinterface

// File: rtl/uart_ring_ctrl.sv
// Runs a dual-port RAM as a circular byte buffer: received bytes are written at
// wr_ptr, and a drain sequence replays them in FIFO order to the UART sender.
module uart_ring_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int RD_LAT      = 2,
    parameter int AUTO_THRESH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_ring_ctrl_if.slave bus
);
    localparam int              DEPTH      = 2 ** ADDR_W;
    localparam int              CNT_W      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W:0] FULL_LVL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] THRESH_LVL = (ADDR_W + 1)'(AUTO_THRESH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        SEND    = 2'd2,
        WAIT_TX = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0] wraddress_q, rdaddress_q;
    logic              wren_q, overflow_q;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q;

    logic full, accept, trigger, tx_complete, rd_last;

    assign full        = (fill_q == FULL_LVL);
    assign accept      = bus.rx_done && !full;
    assign tx_complete = (state_q == WAIT_TX) && bus.tx_done;
    assign rd_last     = (cnt_q == CNT_W'(RD_LAT - 1));
    // Mode is only consulted in IDLE, so flipping auto_mode mid-drain is harmless.
    assign trigger     = (state_q == IDLE) && (fill_q != '0) &&
                         (bus.auto_mode ? (fill_q >= THRESH_LVL)
                                        : (bus.key_flag && !bus.key_state));

    // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fill_d = fill_q;
        if (accept && !tx_complete) begin
            fill_d = fill_q + 1'b1;
        end else if (!accept && tx_complete) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger) state_d = WAIT_RD;
            WAIT_RD: if (rd_last) state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (tx_complete) state_d = (fill_d != '0) ? WAIT_RD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wraddress_q <= '0;
            rdaddress_q <= '0;
            wren_q      <= 1'b0;
            overflow_q  <= 1'b0;
            fill_q      <= '0;
            cnt_q       <= '0;
        end else begin
            wren_q <= accept;
            fill_q <= fill_d;
            if (accept) begin
                wraddress_q <= wr_ptr_q;
                wr_ptr_q    <= wr_ptr_q + 1'b1;
            end
            // A byte dropped in the same cycle a drain starts still leaves the flag set.
            if (bus.rx_done && full) begin
                overflow_q <= 1'b1;
            end else if (trigger) begin
                overflow_q <= 1'b0;
            end
            if (tx_complete) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (trigger) begin
                rdaddress_q <= rd_ptr_q;
            end else if (tx_complete && (fill_d != '0)) begin
                rdaddress_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= (state_q == WAIT_RD) ? cnt_q + 1'b1 : '0;
        end
    end

    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.send_en = (state_q == SEND);
    end

    assign bus.wren       = wren_q;
    assign bus.wraddress  = wraddress_q;
    assign bus.rdaddress  = rdaddress_q;
    assign bus.fill_level = fill_q;
    assign bus.overflow   = overflow_q;
endmodule
